// File: rtl/inv_sub_bytes.sv
// AES InvSubBytes over a 128-bit state, one 32-bit column per cycle through four byte lanes.
// Define INV_SUB_BYTES_FWD_EN to add a dir input that selects the forward S-box per block.
module inv_sub_bytes (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
`ifdef INV_SUB_BYTES_FWD_EN
    input  logic         dir,
`endif
    output logic [127:0] out_data
);

    // Byte b of each table sits at bits [2047-8b -: 8].
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_lookup(input logic [7:0] b);
        return INV_SBOX[11'd2047 - {b, 3'b000} -: 8];
    endfunction

`ifdef INV_SUB_BYTES_FWD_EN
    localparam logic [2047:0] FWD_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] fwd_lookup(input logic [7:0] b);
        return FWD_SBOX[11'd2047 - {b, 3'b000} -: 8];
    endfunction

    logic dir_q;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state_q;
    logic [1:0]     col_q;
    logic [127:0]   work_q;
    logic           in_ready_q;
    logic           out_valid_q;

    logic [6:0]     col_base;
    logic [31:0]    cur_col;
    logic [31:0]    sub_col;

    assign col_base = 7'd127 - {col_q, 5'd0};
    assign cur_col  = work_q[col_base -: 32];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_in;
            assign lane_in = cur_col[31-8*gi -: 8];
`ifdef INV_SUB_BYTES_FWD_EN
            assign sub_col[31-8*gi -: 8] = dir_q ? fwd_lookup(lane_in) : inv_lookup(lane_in);
`else
            assign sub_col[31-8*gi -: 8] = inv_lookup(lane_in);
`endif
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            col_q       <= 2'd0;
            work_q      <= 128'h0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef INV_SUB_BYTES_FWD_EN
            dir_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        work_q     <= in_data;
                        col_q      <= 2'd0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
`ifdef INV_SUB_BYTES_FWD_EN
                        dir_q      <= dir;
`endif
                    end
                end
                RUN: begin
                    work_q[col_base -: 32] <= sub_col;
                    col_q                  <= col_q + 2'd1;
                    if (col_q == 2'd3) begin
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // The ready flag already reads 1 during reset, so reset gates it here.
    assign in_ready  = in_ready_q & ~rst;
    assign out_valid = out_valid_q;
    assign out_data  = work_q;

endmodule
